mac_operand_packer: RTL and testbench

MAC_OPERAND_PACKER -- requirements
Module: mac_operand_packer

---
 rtl/mac_operand_packer.sv | 101 ++++++++++
 tb/tb_mac_operand_packer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_packer.sv
// Packs pairs of operand words into {second, first} messages for a MAC, through a 2-entry output queue.
// Optional odd-length vector padding is compiled in with the MAC_PACKER_PAD_EN macro.
module mac_operand_packer #(
  parameter int p_width = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [p_width-1:0]   in_msg,
  input  logic                 in_last,
  output logic                 req_val,
  input  logic                 req_rdy,
  output logic [2*p_width-1:0] req_msg,
  output logic                 half_full,
  output logic                 fsm_state
);

  // Handshakes: a word moves on in_val && in_rdy, a pair on req_val && req_rdy,
  // both at the rising edge; in_rdy never looks at req_rdy, so there is no bypass path.
  typedef enum logic {FIRST = 1'b0, SECOND = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [p_width-1:0]   hold;
  logic [2*p_width-1:0] mem [2];
  logic                 head, tail;
  logic [1:0]           count;
  logic                 enq, deq, load_hold;
  logic [2*p_width-1:0] enq_data;

`ifndef MAC_PACKER_PAD_EN
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b1;
    enq       = 1'b0;
    load_hold = 1'b0;
    enq_data  = {in_msg, hold};
    case (state)
      FIRST: begin
`ifdef MAC_PACKER_PAD_EN
        // A lone last word goes straight to the queue, so FIRST needs queue space.
        in_rdy = (count != 2'd2);
        if (in_val && in_rdy) begin
          if (in_last) begin
            enq      = 1'b1;
            enq_data = {{p_width{1'b0}}, in_msg};
          end else begin
            load_hold = 1'b1;
            state_nxt = SECOND;
          end
        end
`else
        if (in_val) begin
          load_hold = 1'b1;
          state_nxt = SECOND;
        end
`endif
      end
      SECOND: begin
        in_rdy = (count != 2'd2);
        if (in_val && in_rdy) begin
          enq       = 1'b1;
          state_nxt = FIRST;
        end
      end
      default: state_nxt = FIRST;
    endcase
  end

  assign req_val   = (count != 2'd0);
  assign req_msg   = mem[head];
  assign deq       = req_val && req_rdy;
  assign half_full = (state == SECOND);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FIRST;
      hold  <= '0;
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      state <= state_nxt;
      if (load_hold) hold <= in_msg;
      if (enq) begin
        mem[tail] <= enq_data;
        tail      <= ~tail;
      end
      if (deq) head <= ~head;
      count <= count + {1'b0, enq} - {1'b0, deq};
    end
  end

endmodule

// File: tb/tb_mac_operand_packer.sv
// Directed bench for mac_operand_packer: reset values, pairing, backpressure, reset flush,
// last-word handling and the products a downstream MAC would accumulate.
module tb_mac_operand_packer;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           in_val = 1'b0;
  logic           in_rdy;
  logic [W-1:0]   in_msg = '0;
  logic           in_last = 1'b0;
  logic           req_val;
  logic           req_rdy = 1'b0;
  logic [2*W-1:0] req_msg;
  logic           half_full;
  logic           fsm_state;

  int tests_run = 0;
  int tests_failed = 0;
  int acc = 0;
  int cyc = 0;
  logic [2*W-1:0] exp_q[$];

  mac_operand_packer #(.p_width(W)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .in_last(in_last), .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .half_full(half_full), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every output handshake must match the oldest expected pair
  always @(negedge clk) begin
    if (reset && req_val && req_rdy) begin
      if (exp_q.size() == 0) begin
        check("spurious_pair", 32'(req_msg), 32'hffff_ffff);
      end else begin
        check("pair_order", 32'(req_msg), 32'(exp_q.pop_front()));
      end
      acc = acc + int'(req_msg[2*W-1:W]) * int'(req_msg[W-1:0]);
    end
  end

  // driver: present one word and wait (bounded) for its handshake
  task automatic send_word(input logic [W-1:0] w, input logic last);
    bit done = 0;
    in_val  = 1'b1;
    in_msg  = w;
    in_last = last;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_rdy) done = 1;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_val  = 1'b0;
    in_last = 1'b0;
    if (!done) check("in_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("idle_req_val", 32'(req_val), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_val", 32'(req_val), 32'd0);
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_half_full", 32'(half_full), 32'd0);
    check("rst_req_msg", 32'(req_msg), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    reset = 1'b1;

    // words 3, 5 with downstream ready
    req_rdy = 1'b1;
    exp_q.push_back(16'h0503);
    send_word(8'h03, 1'b0);
    check("pair1_half_full", 32'(half_full), 32'd1);
    send_word(8'h05, 1'b0);
    check("pair1_req_val", 32'(req_val), 32'd1);
    check("pair1_req_msg", 32'(req_msg), 32'h0503);
    check("pair1_half_empty", 32'(half_full), 32'd0);
    wait_drain();

    // backpressure: words 1..5 with req_rdy low fill the queue and the holding register
    req_rdy = 1'b0;
    exp_q.push_back(16'h0201);
    exp_q.push_back(16'h0403);
    exp_q.push_back(16'h0605);
    for (int i = 1; i <= 5; i++) send_word(W'(i), 1'b0);
    check("full_half_full", 32'(half_full), 32'd1);
    check("full_in_rdy", 32'(in_rdy), 32'd0);
    check("full_req_val", 32'(req_val), 32'd1);
    check("full_req_msg", 32'(req_msg), 32'h0201);
    repeat (3) @(posedge clk);
    #1;
    check("stall_req_msg", 32'(req_msg), 32'h0201);
    req_rdy = 1'b1;
    send_word(8'h06, 1'b0);
    wait_drain();

    // back-to-back stream, one word per cycle
    exp_q.push_back(16'h1110);
    exp_q.push_back(16'h1312);
    exp_q.push_back(16'h1514);
    exp_q.push_back(16'h1716);
    cyc = 0;
    for (int i = 0; i < 8; i++) send_word(W'(8'h10 + i), 1'b0);
    check("stream_cycles", 32'(cyc), 32'd8);
    wait_drain();

    // reset while a pair is queued and another is in flight
    req_rdy = 1'b0;
    send_word(8'h07, 1'b0);
    send_word(8'h09, 1'b0);
    send_word(8'h0b, 1'b0);
    check("pre_rst_req_val", 32'(req_val), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_req_val", 32'(req_val), 32'd0);
    check("mid_rst_half_full", 32'(half_full), 32'd0);
    check("mid_rst_req_msg", 32'(req_msg), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_rdy = 1'b1;
    exp_q.push_back(16'h0201);
    send_word(8'h01, 1'b0);
    send_word(8'h02, 1'b0);
    check("post_rst_req_msg", 32'(req_msg), 32'h0201);
    wait_drain();

    // last-word handling
`ifdef MAC_PACKER_PAD_EN
    req_rdy = 1'b0;
    send_word(8'h2a, 1'b1);
    check("pad_req_val", 32'(req_val), 32'd1);
    check("pad_req_msg", 32'(req_msg), 32'h002a);
    check("pad_half_full", 32'(half_full), 32'd0);
    exp_q.push_back(16'h002a);
    req_rdy = 1'b1;
    wait_drain();
`else
    req_rdy = 1'b1;
    send_word(8'h2a, 1'b1);
    check("nopad_half_full", 32'(half_full), 32'd1);
    check("nopad_req_val", 32'(req_val), 32'd0);
    exp_q.push_back(16'h012a);
    send_word(8'h01, 1'b0);
    wait_drain();
`endif

    // products seen by a downstream MAC for words 1, 2, 3, 4
    acc = 0;
    exp_q.push_back(16'h0201);
    exp_q.push_back(16'h0403);
    for (int i = 1; i <= 4; i++) send_word(W'(i), 1'b0);
    wait_drain();
    check("mac_accumulate", 32'(acc), 32'd14);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
